// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, nibble width
// and the step-counter width helper.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // A one-step counter still needs one bit of storage.
    function automatic int cnt_width(input int nib);
        return (nib <= 2) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_rca_4b.sv
// 4-bit ripple-carry adder used as the single shared datapath slice.
// Purely combinational, no flow control.
// No backpressure.
module RCA_4B (
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       C_IN,
    output logic [3:0] SUM,
    output logic       C_OUT
);

    always_comb begin
        logic cy;
        cy  = C_IN;
        SUM = '0;
        for (int i = 0; i < 4; i++) begin
            SUM[i] = X[i] ^ Y[i] ^ cy;
            cy     = (X[i] & Y[i]) | (cy & (X[i] ^ Y[i]));
        end
        C_OUT = cy;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per clock through one RCA_4B.
// Latency: DONE in the cycle after edge k+NIB for a START accepted at edge k.
// START is ignored while BUSY; a new request may be accepted in the DONE cycle.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             C_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             C_OUT,
    output logic             OVF
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int CW  = cnt_width(NIB);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             xmsb_q;
    logic             ymsb_q;
    logic             cout_q;
    logic             ovf_q;

    logic [3:0]       rca_sum;
    logic             rca_co;
    logic             ovf_d;

    RCA_4B u_rca (
        .X     (a_q[3:0]),
        .Y     (b_q[3:0]),
        .C_IN  (carry_q),
        .SUM   (rca_sum),
        .C_OUT (rca_co)
    );

    // The last nibble's SUM[3] becomes the result MSB on entry to DONE.
    assign ovf_d = (xmsb_q == ymsb_q) && (rca_sum[3] != xmsb_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            xmsb_q  <= 1'b0;
            ymsb_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        a_q     <= X;
                        b_q     <= Y;
                        carry_q <= C_IN;
                        cnt_q   <= CW'(NIB - 1);
                        xmsb_q  <= X[WIDTH-1];
                        ymsb_q  <= Y[WIDTH-1];
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> NIBBLE_W;
                    b_q     <= b_q >> NIBBLE_W;
                    sum_q   <= {rca_sum, sum_q[WIDTH-1:NIBBLE_W]};
                    carry_q <= rca_co;
                    if (cnt_q == '0) begin
                        cout_q  <= rca_co;
                        ovf_q   <= ovf_d;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign BUSY  = (state_q == S_RUN);
    assign DONE  = (state_q == S_DONE);
    assign SUM   = sum_q;
    assign C_OUT = cout_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16): directed table, handshake corner
// cases, asynchronous reset and randomized traffic against an arithmetic model.
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         START;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         C_IN;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] SUM;
    logic         C_OUT;
    logic         OVF;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .X     (X),
        .Y     (Y),
        .C_IN  (C_IN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .C_OUT (C_OUT),
        .OVF   (OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain (W+1)-bit addition and the signed-overflow rule.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic cin);
        logic [W:0] full;
        logic       ovf;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
        ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return {ovf, full};
    endfunction

    // Present a request at a negedge; return at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin);
        START = 1'b1;
        X     = x;
        Y     = y;
        C_IN  = cin;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        X     = W'($urandom);
        Y     = W'($urandom);
        C_IN  = 1'($urandom);
    endtask

    task automatic wait_done(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin,
                             input string name, input bit poke);
        int n = 0;
        int busy = 0;
        logic [W+1:0] exp;
        while (!DONE && n < 20) begin
            if (BUSY) busy++;
            if (poke && n == 1) begin
                START = 1'b1;
                X     = 16'hAAAA;
                Y     = 16'h5555;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
            n++;
        end
        exp = model(x, y, cin);
        chk({name, " latency"}, n, 4);
        chk({name, " busy_cycles"}, busy, 4);
        chk({name, " busy_in_done"}, {31'd0, BUSY}, 0);
        chk({name, " sum"}, {16'd0, SUM}, {16'd0, exp[W-1:0]});
        chk({name, " cout"}, {31'd0, C_OUT}, {31'd0, exp[W]});
        chk({name, " ovf"}, {31'd0, OVF}, {31'd0, exp[W+1]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t         tbl[6];
        logic [W-1:0] rx, ry;
        logic         rc;
        logic [W+1:0] exp;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[5] = '{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0};

        RST_N = 1'b0;
        START = 1'b0;
        X     = '0;
        Y     = '0;
        C_IN  = 1'b0;
        #12;
        chk("reset busy", {31'd0, BUSY}, 0);
        chk("reset done", {31'd0, DONE}, 0);
        chk("reset sum", {16'd0, SUM}, 0);
        chk("reset cout", {31'd0, C_OUT}, 0);
        chk("reset ovf", {31'd0, OVF}, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Directed table with hand-computed expectations.
        for (int i = 0; i < 6; i++) begin
            start_op(tbl[i].x, tbl[i].y, tbl[i].cin);
            wait_done(tbl[i].x, tbl[i].y, tbl[i].cin, $sformatf("tbl%0d", i), 1'b0);
            chk($sformatf("tbl%0d sum_const", i), {16'd0, SUM}, {16'd0, tbl[i].sum});
            chk($sformatf("tbl%0d cout_const", i), {31'd0, C_OUT}, {31'd0, tbl[i].cout});
            chk($sformatf("tbl%0d ovf_const", i), {31'd0, OVF}, {31'd0, tbl[i].ovf});
            @(negedge CLK);
            chk($sformatf("tbl%0d done_pulse", i), {31'd0, DONE}, 0);
            chk($sformatf("tbl%0d sum_hold", i), {16'd0, SUM}, {16'd0, tbl[i].sum});
            chk($sformatf("tbl%0d cout_hold", i), {31'd0, C_OUT}, {31'd0, tbl[i].cout});
        end

        // START during RUN is ignored; START in DONE restarts without an IDLE gap.
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(16'h1234, 16'h4321, 1'b0, "ignore_run", 1'b1);
        start_op(16'h0F0F, 16'h0101, 1'b0);
        chk("b2b busy_after_accept", {31'd0, BUSY}, 1);
        wait_done(16'h0F0F, 16'h0101, 1'b0, "b2b", 1'b0);
        chk("b2b sum_const", {16'd0, SUM}, 32'h1010);

        // Asynchronous reset between edges in the middle of RUN.
        @(negedge CLK);
        start_op(16'h1234, 16'h4321, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("midrst busy", {31'd0, BUSY}, 0);
        chk("midrst done", {31'd0, DONE}, 0);
        chk("midrst sum", {16'd0, SUM}, 0);
        chk("midrst cout", {31'd0, C_OUT}, 0);
        chk("midrst ovf", {31'd0, OVF}, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            chk("postrst idle_done", {31'd0, DONE}, 0);
        end
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(16'h1234, 16'h4321, 1'b0, "postrst", 1'b0);

        // Randomized traffic with random gaps (gap 0 is back-to-back).
        for (int t = 0; t < 1000; t++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge CLK);
                chk("rnd gap_done", {31'd0, DONE}, 0);
                if (t > 0) begin
                    exp = model(rx, ry, rc);
                    chk("rnd gap_sum_hold", {16'd0, SUM}, {16'd0, exp[W-1:0]});
                end
            end
            rx = W'($urandom);
            ry = W'($urandom);
            rc = 1'($urandom);
            start_op(rx, ry, rc);
            wait_done(rx, ry, rc, "rnd", 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
